// File: rtl/vga_bus_pkg.sv
// rtl/vga_bus_pkg.sv - shared VGA register map and rectangle-filler FSM states
package vga_bus_pkg;

  localparam logic [7:0] BASE_ADDR_DEFAULT = 8'hB0;

  localparam logic [1:0] REG_X    = 2'd0;
  localparam logic [1:0] REG_Y    = 2'd1;
  localparam logic [1:0] REG_DATA = 2'd2;
  localparam logic [1:0] REG_WE   = 2'd3;

  // ST_REQ doubles as the data-register write: its first granted cycle carries it
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WR_WE0,
    ST_WR_X,
    ST_WR_Y,
    ST_WR_WE1,
    ST_WR_WE0P,
    ST_FIN
  } rect_state_t;

endpackage

// File: rtl/vga_rect_filler_if.sv
// rtl/vga_rect_filler_if.sv - command handshake and bus-master signals of the rectangle filler
interface vga_rect_filler_if;

  logic       CMD_VALID;
  logic       CMD_READY;
  logic [7:0] CMD_X0;
  logic [6:0] CMD_Y0;
  logic [7:0] CMD_W;
  logic [6:0] CMD_H;
  logic       CMD_COLOUR;
  logic       BUSY;
  logic       DONE;
  logic       BUS_REQ;
  logic       BUS_GNT;
  logic [7:0] BUS_ADDR;
  logic       BUS_WE;

  modport master (
    input  CMD_VALID, CMD_X0, CMD_Y0, CMD_W, CMD_H, CMD_COLOUR, BUS_GNT,
    output CMD_READY, BUSY, DONE, BUS_REQ, BUS_ADDR, BUS_WE
  );

  modport slave (
    output CMD_VALID, CMD_X0, CMD_Y0, CMD_W, CMD_H, CMD_COLOUR, BUS_GNT,
    input  CMD_READY, BUSY, DONE, BUS_REQ, BUS_ADDR, BUS_WE
  );

endinterface

// File: rtl/rect_scan_counter.sv
// rtl/rect_scan_counter.sv - loadable x/y offset raster counter with row/rectangle end flags
module rect_scan_counter (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       load,
  input  logic       advance,
  input  logic [7:0] w,
  input  logic [6:0] h,
  output logic [7:0] x_off,
  output logic [6:0] y_off,
  output logic       last_in_row,
  output logic       last_pixel
);

  // Offsets, not absolute coordinates, so edge wrap never confuses the end test
  assign last_in_row = (x_off == w);
  assign last_pixel  = last_in_row && (y_off == h);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      x_off <= 8'd0;
      y_off <= 7'd0;
    end else if (load) begin
      x_off <= 8'd0;
      y_off <= 7'd0;
    end else if (advance) begin
      if (last_in_row) begin
        x_off <= 8'd0;
        y_off <= y_off + 7'd1;
      end else begin
        x_off <= x_off + 8'd1;
      end
    end
  end

endmodule

// File: rtl/vga_rect_filler.sv
// rtl/vga_rect_filler.sv - bus-mastering rectangle fill engine; RECT_FILL_SKIPY_EN writes Y once per row
module vga_rect_filler
  import vga_bus_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
  input  logic                CLK,
  input  logic                RESET_N,
  vga_rect_filler_if.master   bus,
  inout  wire  [7:0]          BUS_DATA
);

  rect_state_t state, state_nxt;
  logic [7:0]  x0_q, w_q;
  logic [6:0]  y0_q, h_q;
  logic        colour_q;
  logic        accept, in_bus, owned, advance;
  logic [7:0]  x_off;
  logic [6:0]  y_off;
  logic        last_in_row, last_pixel;
  logic [1:0]  reg_sel;
  logic [7:0]  wr_data;

  assign accept        = bus.CMD_VALID && (state == ST_IDLE);
  assign in_bus        = (state != ST_IDLE) && (state != ST_FIN);
  assign owned         = in_bus && bus.BUS_GNT;
  assign bus.CMD_READY = (state == ST_IDLE);
  assign bus.BUSY      = (state != ST_IDLE);
  assign bus.DONE      = (state == ST_FIN);
  assign bus.BUS_REQ   = in_bus;
  assign bus.BUS_ADDR  = owned ? (BASE_ADDR + {6'd0, reg_sel}) : 8'h00;
  assign bus.BUS_WE    = owned;
  assign BUS_DATA      = owned ? wr_data : 8'hzz;

  rect_scan_counter u_scan (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .load        (accept),
    .advance     (advance),
    .w           (w_q),
    .h           (h_q),
    .x_off       (x_off),
    .y_off       (y_off),
    .last_in_row (last_in_row),
    .last_pixel  (last_pixel)
  );

`ifdef RECT_FILL_SKIPY_EN
  logic row_start;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)     row_start <= 1'b0;
    else if (accept)  row_start <= 1'b1;
    else if (advance) row_start <= last_in_row;
  end
`else
  logic unused_last_in_row;
  assign unused_last_in_row = last_in_row;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= ST_IDLE;
      x0_q     <= 8'd0;
      y0_q     <= 7'd0;
      w_q      <= 8'd0;
      h_q      <= 7'd0;
      colour_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        x0_q     <= bus.CMD_X0;
        y0_q     <= bus.CMD_Y0;
        w_q      <= bus.CMD_W;
        h_q      <= bus.CMD_H;
        colour_q <= bus.CMD_COLOUR;
      end
    end
  end

  // Without grant the state holds, so the same write is reissued on return
  always_comb begin
    state_nxt = state;
    reg_sel   = REG_DATA;
    wr_data   = 8'h00;
    advance   = 1'b0;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_REQ;
      ST_REQ: begin
        wr_data = {7'd0, colour_q};
        if (bus.BUS_GNT) state_nxt = ST_WR_WE0;
      end
      ST_WR_WE0: begin
        reg_sel = REG_WE;
        if (bus.BUS_GNT) state_nxt = ST_WR_X;
      end
      ST_WR_X: begin
        reg_sel = REG_X;
        wr_data = x0_q + x_off;
`ifdef RECT_FILL_SKIPY_EN
        if (bus.BUS_GNT) state_nxt = row_start ? ST_WR_Y : ST_WR_WE1;
`else
        if (bus.BUS_GNT) state_nxt = ST_WR_Y;
`endif
      end
      ST_WR_Y: begin
        reg_sel = REG_Y;
        wr_data = {1'b0, y0_q + y_off};
        if (bus.BUS_GNT) state_nxt = ST_WR_WE1;
      end
      ST_WR_WE1: begin
        reg_sel = REG_WE;
        wr_data = 8'h01;
        if (bus.BUS_GNT) state_nxt = ST_WR_WE0P;
      end
      ST_WR_WE0P: begin
        reg_sel = REG_WE;
        if (bus.BUS_GNT) begin
          if (last_pixel) begin
            state_nxt = ST_FIN;
          end else begin
            advance   = 1'b1;
            state_nxt = ST_WR_X;
          end
        end
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
